// File: rtl/exa_crosb_hdr_stage_if.sv
// AXI-Stream beat bundle (128-bit data) shared by the ingress and egress
// sides of the crossbar header stage.
interface exa_crosb_hdr_stage_if;
  logic [127:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/exa_crosb_hdr_stage.sv
// Crossbar per-port header stage: captures each packet header, waits for routing,
// emits the modified header then streams the body. Drop of undecodable packets: EXA_CROSB_HDR_DROP_EN.
module exa_crosb_hdr_stage #(
  parameter int TDEST_WIDTH = 3,
  parameter int PKT_CNT_W   = 32
`ifdef EXA_CROSB_HDR_DROP_EN
  ,
  parameter int DROP_CNT_W  = 16
`endif
) (
  input  logic                   Clk,
  input  logic                   Reset,
  exa_crosb_hdr_stage_if.slave   s_axis,
  output logic [127:0]           o_header,
  output logic                   o_hdr_valid,
  input  logic [127:0]           i_mod_header,
  input  logic [TDEST_WIDTH-1:0] i_tdest,
  input  logic                   i_prio,
  input  logic                   i_dest_valid,
  input  logic                   i_dec_error,
  exa_crosb_hdr_stage_if.master  m_axis,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest,
  output logic                   o_prio,
  output logic [PKT_CNT_W-1:0]   o_pkt_cnt,
  output logic                   o_stall_err
`ifdef EXA_CROSB_HDR_DROP_EN
  ,
  output logic [DROP_CNT_W-1:0]  o_drop_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOOKUP, HEAD, BODY, DROP} state_t;

  state_t                 state_q, state_d;
  logic [127:0]           hdr_q, hdr_d;
  logic                   hdr_last_q, hdr_last_d;
  logic [127:0]           mod_hdr_q, mod_hdr_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                   prio_q, prio_d;
  logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic                   stall_err_q, stall_err_d;
`ifdef EXA_CROSB_HDR_DROP_EN
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    hdr_last_d    = hdr_last_q;
    mod_hdr_d     = mod_hdr_q;
    tdest_d       = tdest_q;
    prio_d        = prio_q;
    pkt_cnt_d     = pkt_cnt_q;
    stall_err_d   = stall_err_q;
`ifdef EXA_CROSB_HDR_DROP_EN
    drop_cnt_d    = drop_cnt_q;
`endif
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = mod_hdr_q;
    m_axis.tlast  = hdr_last_q;
    o_hdr_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        s_axis.tready = 1'b1;
        if (s_axis.tvalid) begin
          hdr_d      = s_axis.tdata;
          hdr_last_d = s_axis.tlast;
          state_d    = LOOKUP;
        end
      end

      LOOKUP: begin
        o_hdr_valid = 1'b1;
        // A decode error outranks a simultaneous destination; once stalled the port ignores routing.
        if (i_dec_error) begin
`ifdef EXA_CROSB_HDR_DROP_EN
          state_d = hdr_last_q ? IDLE : DROP;
          if (drop_cnt_q != {DROP_CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
`else
          stall_err_d = 1'b1;
`endif
        end else if (i_dest_valid && !stall_err_q) begin
          mod_hdr_d = i_mod_header;
          tdest_d   = i_tdest;
          prio_d    = i_prio;
          state_d   = HEAD;
        end
      end

      HEAD: begin
        m_axis.tvalid = 1'b1;
        if (m_axis.tready) state_d = hdr_last_q ? IDLE : BODY;
      end

      BODY: begin
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tdata  = s_axis.tdata;
        m_axis.tlast  = s_axis.tlast;
        s_axis.tready = m_axis.tready;
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) state_d = IDLE;
      end

      DROP: begin
        s_axis.tready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (m_axis.tvalid && m_axis.tready && m_axis.tlast) pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      hdr_last_q  <= 1'b0;
      mod_hdr_q   <= '0;
      tdest_q     <= '0;
      prio_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      stall_err_q <= 1'b0;
`ifdef EXA_CROSB_HDR_DROP_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_last_q  <= hdr_last_d;
      mod_hdr_q   <= mod_hdr_d;
      tdest_q     <= tdest_d;
      prio_q      <= prio_d;
      pkt_cnt_q   <= pkt_cnt_d;
      stall_err_q <= stall_err_d;
`ifdef EXA_CROSB_HDR_DROP_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  assign o_header     = hdr_q;
  assign m_axis_tdest = tdest_q;
  assign o_prio       = prio_q;
  assign o_pkt_cnt    = pkt_cnt_q;
  assign o_stall_err  = stall_err_q;
`ifdef EXA_CROSB_HDR_DROP_EN
  assign o_drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_exa_crosb_hdr_stage.sv
// Self-checking bench for exa_crosb_hdr_stage: packet-level reference model,
// table-driven vectors, hand-written corner sequences and randomized traffic.
module tb_exa_crosb_hdr_stage;

  localparam logic [127:0] MASK = 128'h00F0_0000_0000_0000_0000_0000_0000_0A05;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [127:0] o_header;
  logic         o_hdr_valid;
  logic [127:0] i_mod_header;
  logic [2:0]   i_tdest = '0;
  logic         i_prio = 1'b0;
  logic         i_dest_valid = 1'b0;
  logic         i_dec_error = 1'b0;
  logic [2:0]   m_axis_tdest;
  logic         o_prio;
  logic [31:0]  o_pkt_cnt;
  logic         o_stall_err;
`ifdef EXA_CROSB_HDR_DROP_EN
  logic [15:0]  o_drop_cnt;
`endif

  exa_crosb_hdr_stage_if s_axis ();
  exa_crosb_hdr_stage_if m_axis ();

  exa_crosb_hdr_stage dut (
    .Clk(Clk), .Reset(Reset), .s_axis(s_axis),
    .o_header(o_header), .o_hdr_valid(o_hdr_valid),
    .i_mod_header(i_mod_header), .i_tdest(i_tdest), .i_prio(i_prio),
    .i_dest_valid(i_dest_valid), .i_dec_error(i_dec_error),
    .m_axis(m_axis), .m_axis_tdest(m_axis_tdest), .o_prio(o_prio),
    .o_pkt_cnt(o_pkt_cnt), .o_stall_err(o_stall_err)
`ifdef EXA_CROSB_HDR_DROP_EN
    , .o_drop_cnt(o_drop_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  // router model: modifies the header it is shown by a fixed bit mask
  assign i_mod_header = o_header ^ MASK;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    bit           last;
    logic [2:0]   td;
    bit           pr;
    bit           is_hdr;
  } beat_t;

  typedef struct {
    int         nb;
    int         dly;
    logic [2:0] td;
    bit         pr;
    int         rmode;
    int         exp_cnt;
  } vec_t;

  beat_t        exp_q[$];
  int           n_chk = 0, n_fail = 0;
  int           exp_pkt = 0, exp_drop = 0;
  int           hdr_cyc = 0, last_tl_cyc = 0;
  logic [127:0] cur_hdr = '0;
  int           rt_delay = 0, rt_cnt = 0;
  bit           rt_err = 0, rt_prio = 0;
  logic [2:0]   rt_tdest = '0;
  int           tready_mode = 0, hold = 0;
  bit           in_body = 0, lat_done = 0, prev_stall = 0;
  logic [127:0] prev_data = '0;
  logic [2:0]   prev_dest = '0;
  vec_t         vt[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send_pkt(input int nb, input int dly, input bit err, input logic [2:0] td,
                          input bit pr, input int abort_after, input int budget, output bit ok);
    logic [127:0] beat;
    beat_t        e;
    int           w;
    ok = 1'b1;
    for (int b = 0; b < nb; b++) begin
      if (b == abort_after) return;
      beat = {$urandom, $urandom, $urandom, $urandom};
      @(negedge Clk);
      s_axis.tdata  = beat;
      s_axis.tlast  = (b == nb - 1);
      s_axis.tvalid = 1'b1;
      #1;
      w = 0;
      while (!s_axis.tready) begin
        w++;
        if (w > budget) begin
          ok = 1'b0;
          s_axis.tvalid = 1'b0;
          return;
        end
        @(negedge Clk); #1;
      end
      if (b == 0) begin
        hdr_cyc  = cyc + 1;
        cur_hdr  = beat;
        rt_delay = dly;
        rt_err   = err;
        rt_tdest = td;
        rt_prio  = pr;
        if (err && exp_drop < 65535) exp_drop++;
      end
      if (!err) begin
        e.data   = (b == 0) ? (beat ^ MASK) : beat;
        e.last   = (b == nb - 1);
        e.td     = td;
        e.pr     = pr;
        e.is_hdr = (b == 0);
        exp_q.push_back(e);
      end
    end
    @(posedge Clk); #1;
    s_axis.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge Clk); #3;
      w++;
    end
    chk(nm, exp_q.size(), 0);
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    s_axis.tvalid = 1'b0;
    exp_drop = 0;
    @(posedge Clk); #1;
    chk("rst_s_tready", s_axis.tready, 1);
    chk("rst_m_tvalid", m_axis.tvalid, 0);
    chk("rst_hdr_valid", o_hdr_valid, 0);
    chk("rst_pkt_cnt", o_pkt_cnt, 0);
    chk("rst_stall_err", o_stall_err, 0);
    chk("rst_tdest", m_axis_tdest, 0);
    chk("rst_prio", o_prio, 0);
    chk("rst_header", o_header, 0);
`ifdef EXA_CROSB_HDR_DROP_EN
    chk("rst_drop_cnt", o_drop_cnt, 0);
`endif
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    bit ok;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;

    fork
      begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
      begin : router
        forever begin
          @(negedge Clk);
          if (o_hdr_valid && !Reset) begin
            chk("lookup_header", o_header, cur_hdr);
            chk("lookup_s_tready", s_axis.tready, 0);
            chk("lookup_m_tvalid", m_axis.tvalid, 0);
            if (rt_cnt >= rt_delay) begin
              i_dec_error  = rt_err;
              i_dest_valid = rt_err ? 1'($urandom % 2) : 1'b1;
              i_tdest      = rt_err ? 3'($urandom) : rt_tdest;
              i_prio       = rt_err ? 1'($urandom) : rt_prio;
            end else begin
              i_dec_error  = 1'b0;
              i_dest_valid = 1'b0;
              i_tdest      = 3'($urandom);
              i_prio       = 1'($urandom);
            end
            rt_cnt++;
          end else begin
            if (rt_cnt > 0 && !rt_err && !Reset) chk("hdr_valid_cycles", rt_cnt, rt_delay + 1);
            rt_cnt       = 0;
            i_dec_error  = 1'b0;
            i_dest_valid = 1'b0;
          end
        end
      end
      begin : monitor
        beat_t e;
        forever begin
          @(negedge Clk);
          case (tready_mode)
            0: m_axis.tready = 1'b1;
            1: m_axis.tready = 1'($urandom % 2);
            default: begin
              if (exp_q.size() > 0 && exp_q[0].is_hdr && m_axis.tvalid && hold < 3) begin
                m_axis.tready = 1'b0;
                hold++;
              end else m_axis.tready = 1'($urandom % 2);
            end
          endcase
          #2;
          if (Reset) begin
            exp_q.delete();
            exp_pkt = 0; in_body = 0; prev_stall = 0; lat_done = 0; hold = 0;
            continue;
          end
          if (prev_stall) begin
            chk("stall_valid_held", m_axis.tvalid, 1);
            chk("stall_data_stable", m_axis.tdata, prev_data);
            chk("stall_tdest_stable", m_axis_tdest, prev_dest);
          end
          if (in_body) begin
            chk("body_s_tready", s_axis.tready, m_axis.tready);
            chk("body_m_tvalid", m_axis.tvalid, s_axis.tvalid);
          end
          if (m_axis.tvalid && exp_q.size() > 0 && exp_q[0].is_hdr && !lat_done) begin
            chk("hdr_latency", cyc, hdr_cyc + 1 + rt_delay);
            lat_done = 1;
          end
          if (m_axis.tvalid && m_axis.tready) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
              e = exp_q.pop_front();
              chk("m_tdata", m_axis.tdata, e.data);
              chk("m_tlast", m_axis.tlast, e.last);
              chk("m_tdest", m_axis_tdest, e.td);
              chk("m_prio", o_prio, e.pr);
              if (e.is_hdr) begin
                lat_done = 0;
                hold     = 0;
                in_body  = !e.last;
              end
              if (e.last) begin
                exp_pkt++;
                last_tl_cyc = cyc + 1;
                in_body     = 0;
              end
            end
          end
          prev_stall = m_axis.tvalid && !m_axis.tready;
          prev_data  = m_axis.tdata;
          prev_dest  = m_axis_tdest;
        end
      end
    join_none

    // nb, router delay, tdest, prio, m_tready mode, expected o_pkt_cnt afterwards
    vt[0] = '{4, 0, 3'd5, 1'b0, 0, 1};
    vt[1] = '{1, 0, 3'd2, 1'b1, 0, 2};
    vt[2] = '{3, 2, 3'd3, 1'b0, 0, 3};
    vt[3] = '{5, 1, 3'd6, 1'b1, 1, 4};
    vt[4] = '{1, 3, 3'd7, 1'b0, 1, 5};
    vt[5] = '{6, 0, 3'd0, 1'b1, 2, 6};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      tready_mode = vt[i].rmode;
      send_pkt(vt[i].nb, vt[i].dly, 1'b0, vt[i].td, vt[i].pr, -1, 200, ok);
      chk("vec_send_ok", ok, 1);
      wait_drain("vec_drain");
      chk("vec_pkt_cnt", o_pkt_cnt, vt[i].exp_cnt);
      chk("vec_tdest_held", m_axis_tdest, vt[i].td);
      chk("vec_prio_held", o_prio, vt[i].pr);
    end

    // two back-to-back single-beat packets: one idle bubble between them
    tready_mode = 0;
    send_pkt(1, 0, 1'b0, 3'd1, 1'b0, -1, 200, ok);
    send_pkt(1, 0, 1'b0, 3'd4, 1'b1, -1, 200, ok);
    chk("b2b_hdr_accept_cycle", hdr_cyc, last_tl_cyc + 1);
    wait_drain("b2b_drain");
    chk("b2b_pkt_cnt", o_pkt_cnt, exp_pkt);

    // HEAD back-pressured 3 cycles, random ready in body
    tready_mode = 2;
    send_pkt(5, 0, 1'b0, 3'd6, 1'b1, -1, 200, ok);
    chk("stall_send_ok", ok, 1);
    wait_drain("stall_drain");
    chk("stall_pkt_cnt", o_pkt_cnt, exp_pkt);

    // decode error on a 3-beat packet
    tready_mode = 0;
`ifdef EXA_CROSB_HDR_DROP_EN
    send_pkt(3, 0, 1'b1, 3'd0, 1'b0, -1, 50, ok);
    chk("drop_consumed", ok, 1);
    @(posedge Clk); #1;
    chk("drop_cnt", o_drop_cnt, exp_drop);
    chk("drop_no_stall_err", o_stall_err, 0);
    send_pkt(2, 1, 1'b0, 3'd3, 1'b1, -1, 200, ok);
    wait_drain("after_drop_drain");
    chk("after_drop_pkt_cnt", o_pkt_cnt, exp_pkt);
`else
    send_pkt(3, 0, 1'b1, 3'd0, 1'b0, -1, 15, ok);
    chk("err_port_stalled", ok, 0);
    chk("err_stall_err", o_stall_err, 1);
    chk("err_s_tready_low", s_axis.tready, 0);
    chk("err_m_tvalid_low", m_axis.tvalid, 0);
    chk("err_pkt_cnt", o_pkt_cnt, exp_pkt);
    do_reset();
`endif

    // reset in BODY mid-packet
    send_pkt(2, 0, 1'b0, 3'd2, 1'b0, -1, 200, ok);
    wait_drain("pre_reset_drain");
    tready_mode = 0;
    send_pkt(4, 0, 1'b0, 3'd5, 1'b1, 2, 200, ok);
    do_reset();

    // randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      bit err;
`ifdef EXA_CROSB_HDR_DROP_EN
      err = ($urandom % 6) == 0;
`else
      err = 1'b0;
`endif
      tready_mode = int'($urandom % 3);
      send_pkt(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), err, 3'($urandom),
               1'($urandom), -1, 300, ok);
      chk("rand_send_ok", ok, 1);
    end
    wait_drain("rand_drain");
    chk("rand_pkt_cnt", o_pkt_cnt, exp_pkt);
`ifdef EXA_CROSB_HDR_DROP_EN
    chk("rand_drop_cnt", o_drop_cnt, exp_drop);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
